// File: rtl/cpu_bus_bridge_if.sv
// Bus side of the CPU bridge: one outstanding address/data-phase transaction.
interface cpu_bus_bridge_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/cpu_bus_bridge.sv
// Arbitrates fetch and MEM-stage accesses onto a single-outstanding split-phase bus.
// Data has priority; results are kept until the pipeline stops stalling.
module cpu_bus_bridge #(
    parameter bit UNCACHE_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        stallreq_from_if,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        stallreq_from_mem,
    input  logic        longest_stall,
    cpu_bus_bridge_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] inst_rdata_q;
    logic [DW-1:0] data_rdata_q;
    logic          inst_done_q;
    logic          data_done_q;
    logic          req_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW-1:0] baddr_q;
    logic [DW-1:0] wdata_q;

    logic inst_pend, data_pend, inst_hit, data_hit;

    // Unmapped uncached segment: strip the segment bits, compare virtual elsewhere.
    function automatic logic [AW-1:0] phys(input logic [AW-1:0] va);
        if (UNCACHE_MAP && va[31:30] == 2'b10) return {3'b000, va[28:0]};
        return va;
    endfunction

    function automatic logic [1:0] wsize(input logic [3:0] wen);
        case (wen)
            4'b1111:          return 2'd2;
            4'b0011, 4'b1100: return 2'd1;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] woff(input logic [3:0] wen);
        if (wen[0]) return 2'd0;
        if (wen[1]) return 2'd1;
        if (wen[2]) return 2'd2;
        if (wen[3]) return 2'd3;
        return 2'd0;
    endfunction

    assign inst_pend = inst_req & ~inst_done_q;
    assign data_pend = data_en & ~data_done_q;
    // A completing transaction only counts if the requester still wants that address.
    assign inst_hit  = (state_q == I_DATA) & bus.bus_data_ok & inst_req & (inst_addr == addr_q);
    assign data_hit  = (state_q == D_DATA) & bus.bus_data_ok & data_en & (data_addr == addr_q);

    assign stallreq_from_if  = rst & inst_pend;
    assign stallreq_from_mem = rst & data_pend;
    assign inst_rdata        = inst_rdata_q;
    assign data_rdata        = data_rdata_q;
    assign bus.bus_req       = req_q;
    assign bus.bus_wr        = wr_q;
    assign bus.bus_size      = size_q;
    assign bus.bus_addr      = baddr_q;
    assign bus.bus_wdata     = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            baddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            // Done flags live only while the pipeline is frozen.
            inst_done_q <= longest_stall & (inst_done_q | inst_hit);
            data_done_q <= longest_stall & (data_done_q | data_hit);
            if (inst_hit) inst_rdata_q <= bus.bus_rdata;
            if (data_hit && !wr_q) data_rdata_q <= bus.bus_rdata;

            case (state_q)
                IDLE: begin
                    if (data_pend) begin
                        state_q <= D_ADDR;
                        req_q   <= 1'b1;
                        addr_q  <= data_addr;
                        wr_q    <= |data_wen;
                        wdata_q <= data_wdata;
                        if (|data_wen) begin
                            size_q  <= wsize(data_wen);
                            baddr_q <= phys({data_addr[31:2], woff(data_wen)});
                        end else begin
                            size_q  <= 2'd2;
                            baddr_q <= phys({data_addr[31:2], 2'b00});
                        end
                    end else if (inst_pend) begin
                        state_q <= I_ADDR;
                        req_q   <= 1'b1;
                        addr_q  <= inst_addr;
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                        size_q  <= 2'd2;
                        baddr_q <= phys({inst_addr[31:2], 2'b00});
                    end
                end
                D_ADDR: if (bus.bus_addr_ok) begin
                    req_q   <= 1'b0;
                    state_q <= D_DATA;
                end
                I_ADDR: if (bus.bus_addr_ok) begin
                    req_q   <= 1'b0;
                    state_q <= I_DATA;
                end
                D_DATA, I_DATA: if (bus.bus_data_ok) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed and randomized checks of cpu_bus_bridge against a transaction-level model.
module tb_cpu_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        stallreq_from_if;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stallreq_from_mem;
    logic        longest_stall;
    logic        hold_stall;

    int checks = 0;
    int errors = 0;

    cpu_bus_bridge_if bus_if ();

    cpu_bus_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .stallreq_from_if(stallreq_from_if),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .stallreq_from_mem(stallreq_from_mem),
        .longest_stall(longest_stall),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // The pipeline freezes whenever either side of the bridge stalls.
    assign longest_stall = stallreq_from_if | stallreq_from_mem | hold_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va & 32'h1FFF_FFFF;
        return va;
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] wen);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(wen[i]);
        if (n == 0 || n == 4) return 2'd2;
        if (n == 2) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] va, input logic [3:0] wen);
        logic [31:0] a = m_phys(va) & 32'hFFFF_FFFC;
        for (int i = 3; i >= 0; i--) if (wen[i]) a = (a & 32'hFFFF_FFFC) | 32'(i);
        return a;
    endfunction

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && bus_if.bus_req !== 1'b1; i++) @(negedge clk);
        chk({tag, "_req_seen"}, 32'(bus_if.bus_req), 32'd1);
    endtask

    task automatic check_req(input string tag, input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, "_wr"},   32'(bus_if.bus_wr),   32'(wr));
        chk({tag, "_size"}, 32'(bus_if.bus_size), 32'(size));
        chk({tag, "_addr"}, bus_if.bus_addr,      addr);
        if (wr) chk({tag, "_wdata"}, bus_if.bus_wdata, wdata);
    endtask

    task automatic do_addr(input string tag, input int delay, input logic [31:0] addr);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold_req"},  32'(bus_if.bus_req), 32'd1);
            chk({tag, "_hold_addr"}, bus_if.bus_addr,     addr);
        end
        bus_if.bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_if.bus_addr_ok = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus_if.bus_req), 32'd0);
    endtask

    task automatic do_data(input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) @(negedge clk);
        bus_if.bus_rdata   = rdata;
        bus_if.bus_data_ok = 1'b1;
        @(negedge clk);
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = $urandom;
    endtask

    logic [31:0] exp_ird, exp_drd, r, rd;
    logic [3:0]  wtab [7];
    logic [2:0]  kind;
    logic        do_i, do_d, dwr;

    initial begin
        wtab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        rst = 1'b0; hold_stall = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0040; data_wdata = 32'h1234_5678;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'hFFFF_FFFF;
        exp_ird = '0; exp_drd = '0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req",  32'(bus_if.bus_req),  32'd0);
        chk("rst_bus_addr", bus_if.bus_addr,      32'd0);
        chk("rst_bus_size", 32'(bus_if.bus_size), 32'd0);
        chk("rst_stall_if", 32'(stallreq_from_if),  32'd0);
        chk("rst_stall_mem", 32'(stallreq_from_mem), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        inst_req = 1'b0; data_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single fetch with minimum latency.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1 chk("f_stall_t0", 32'(stallreq_from_if), 32'd1);
        @(negedge clk);
        chk("f_req_t1", 32'(bus_if.bus_req), 32'd1);
        check_req("f", 1'b0, 2'd2, 32'h1FC0_0000, 32'd0);
        chk("f_stall_t1", 32'(stallreq_from_if), 32'd1);
        bus_if.bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_if.bus_addr_ok = 1'b0;
        chk("f_req_t2", 32'(bus_if.bus_req), 32'd0);
        chk("f_stall_t2", 32'(stallreq_from_if), 32'd1);
        bus_if.bus_rdata = 32'h2402_0001; bus_if.bus_data_ok = 1'b1;
        @(negedge clk);
        bus_if.bus_data_ok = 1'b0;
        exp_ird = 32'h2402_0001;
        chk("f_stall_t3", 32'(stallreq_from_if), 32'd0);
        chk("f_rdata_t3", inst_rdata, exp_ird);
        inst_req = 1'b0;
        @(negedge clk);

        // Data wins over a simultaneous fetch.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0010;
        wait_req("p_d");
        check_req("p_d", 1'b0, 2'd2, 32'h0000_0010, 32'd0);
        do_addr("p_d", 1, 32'h0000_0010);
        do_data(1, 32'hCAFE_0010);
        exp_drd = 32'hCAFE_0010;
        chk("p_mem_drop", 32'(stallreq_from_mem), 32'd0);
        chk("p_if_still", 32'(stallreq_from_if),  32'd1);
        wait_req("p_i");
        check_req("p_i", 1'b0, 2'd2, 32'h1FC0_0004, 32'd0);
        do_addr("p_i", 0, 32'h1FC0_0004);
        do_data(0, 32'h0000_0004);
        exp_ird = 32'h0000_0004;
        chk("p_if_drop", 32'(stallreq_from_if), 32'd0);
        chk("p_drdata", data_rdata, exp_drd);
        chk("p_irdata", inst_rdata, exp_ird);
        inst_req = 1'b0; data_en = 1'b0;
        @(negedge clk);

        // Halfword store on the upper lanes.
        data_en = 1'b1; data_wen = 4'b1100; data_addr = 32'h8000_1002; data_wdata = 32'hBEEF_0000;
        wait_req("hs");
        check_req("hs", 1'b1, 2'd1, 32'h0000_1002, 32'hBEEF_0000);
        do_addr("hs", 2, 32'h0000_1002);
        do_data(0, 32'h5555_5555);
        chk("hs_stall", 32'(stallreq_from_mem), 32'd0);
        chk("hs_rdata_kept", data_rdata, exp_drd);
        data_en = 1'b0; data_wen = 4'b0000;
        @(negedge clk);

        // Fetch redirected while its data phase is outstanding.
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        wait_req("fl_old");
        check_req("fl_old", 1'b0, 2'd2, 32'h0000_0100, 32'd0);
        do_addr("fl_old", 0, 32'h0000_0100);
        inst_addr = 32'h0000_0380;
        do_data(1, 32'hDEAD_0100);
        chk("fl_still_stall", 32'(stallreq_from_if), 32'd1);
        chk("fl_discard", inst_rdata, exp_ird);
        wait_req("fl_new");
        check_req("fl_new", 1'b0, 2'd2, 32'h0000_0380, 32'd0);
        do_addr("fl_new", 0, 32'h0000_0380);
        do_data(0, 32'h0000_3800);
        exp_ird = 32'h0000_3800;
        chk("fl_done", 32'(stallreq_from_if), 32'd0);
        chk("fl_rdata", inst_rdata, exp_ird);

        // Pipeline frozen after the fetch completes: no refetch until it moves.
        hold_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sh_no_req", 32'(bus_if.bus_req), 32'd0);
            chk("sh_no_stall", 32'(stallreq_from_if), 32'd0);
            chk("sh_rdata", inst_rdata, exp_ird);
        end
        hold_stall = 1'b0;
        @(negedge clk);
        chk("sh_done_cleared", 32'(stallreq_from_if), 32'd1);
        inst_req = 1'b0;
        @(negedge clk);
        chk("sh_idle", 32'(bus_if.bus_req), 32'd0);

        // Reset while a read is in its data phase.
        data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'hA000_0200;
        wait_req("rd");
        do_addr("rd", 0, 32'h0000_0200);
        rst = 1'b0;
        #1;
        chk("rr_bus_addr",   bus_if.bus_addr,       32'd0);
        chk("rr_bus_wr",     32'(bus_if.bus_wr),    32'd0);
        chk("rr_bus_wdata",  bus_if.bus_wdata,      32'd0);
        chk("rr_data_rdata", data_rdata,            32'd0);
        chk("rr_inst_rdata", inst_rdata,            32'd0);
        chk("rr_stall_mem",  32'(stallreq_from_mem), 32'd0);
        exp_ird = '0; exp_drd = '0;
        data_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_data(0, 32'h7777_7777);
        chk("rr_stray_rdata", data_rdata, 32'd0);
        chk("rr_stray_req", 32'(bus_if.bus_req), 32'd0);
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        @(negedge clk);
        chk("rr_after_req", 32'(bus_if.bus_req), 32'd1);
        check_req("rr_after", 1'b0, 2'd2, 32'h0000_0400, 32'd0);
        do_addr("rr_after", 0, 32'h0000_0400);
        do_data(0, 32'h0000_4000);
        exp_ird = 32'h0000_4000;
        chk("rr_after_rdata", inst_rdata, exp_ird);
        inst_req = 1'b0;
        @(negedge clk);

        // Random mix of fetches, loads and stores with random bus latency.
        for (int it = 0; it < 40; it++) begin
            kind = 3'($urandom_range(0, 4));
            do_i = (kind == 3'd0) || (kind >= 3'd3);
            do_d = (kind != 3'd0);
            dwr  = (kind == 3'd2) || (kind == 3'd4);
            r = $urandom;
            inst_addr = {4'($urandom_range(0, 15)), r[27:2], 2'b00};
            r = $urandom;
            data_addr = {4'($urandom_range(0, 15)), r[27:0]};
            data_wen  = dwr ? wtab[3'($urandom_range(0, 6))] : 4'b0000;
            if (dwr) data_addr = m_addr(data_addr, data_wen) | (data_addr & 32'hE000_0000);
            data_wdata = $urandom;
            inst_req = do_i; data_en = do_d;
            if (do_d) begin
                wait_req("rn_d");
                check_req("rn_d", dwr, m_size(data_wen), m_addr(data_addr, data_wen), data_wdata);
                do_addr("rn_d", $urandom_range(0, 2), m_addr(data_addr, data_wen));
                rd = $urandom;
                do_data($urandom_range(0, 2), rd);
                if (!dwr) exp_drd = rd;
                chk("rn_mem_drop", 32'(stallreq_from_mem), 32'd0);
                chk("rn_if_wait", 32'(stallreq_from_if), 32'(do_i));
            end
            if (do_i) begin
                wait_req("rn_i");
                check_req("rn_i", 1'b0, 2'd2, m_phys(inst_addr) & 32'hFFFF_FFFC, 32'd0);
                do_addr("rn_i", $urandom_range(0, 2), m_phys(inst_addr));
                rd = $urandom;
                do_data($urandom_range(0, 2), rd);
                exp_ird = rd;
                chk("rn_if_drop", 32'(stallreq_from_if), 32'd0);
            end
            chk("rn_irdata", inst_rdata, exp_ird);
            chk("rn_drdata", data_rdata, exp_drd);
            inst_req = 1'b0; data_en = 1'b0;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
